alu_arbiter: RTL

- Shares the single combinational ALU (AND/OR/ADD/SUB/MUL, 4-bit control) between N_REQ requesters, e.g. the main datapath and the branch/address unit.
- Accepts one operation at a time under valid/ready handshake and selects round-robin.
- Drives the ALU from registered operands, holds multiply for MUL_CYCLES, and returns the result, zero flag and requester id on a valid/ready response channel.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, FSM states and
// the legal-code check.
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0011;
  localparam alu_ctrl_t ALU_MUL = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_WAIT,
    ST_RESP
  } arb_state_t;

  // Legal codes are contiguous from AND up to MUL.
  function automatic logic is_legal_ctrl(alu_ctrl_t ctrl);
    return (ctrl <= ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response signals of the ALU arbiter.
// The slave modport is the arbiter's view.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_op1;
  logic [N_REQ*DATA_W-1:0] req_op2;
  logic [N_REQ*4-1:0]      req_ctrl;

  logic [DATA_W-1:0]       alu_op1;
  logic [DATA_W-1:0]       alu_op2;
  alu_ctrl_t               alu_ctrl;
  logic [DATA_W-1:0]       alu_res;
  logic                    alu_zero;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_res;
  logic                    rsp_zero;
  logic                    rsp_err;

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, alu_res, alu_zero, rsp_ready,
    output req_ready, alu_op1, alu_op2, alu_ctrl,
    output rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, alu_res, alu_zero, rsp_ready,
    input  req_ready, alu_op1, alu_op2, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: one-hot grant among valid requesters, searching from the
// requester after the last accepted one.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] last_q;
  logic            found;
  int              cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (enable && !found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin accept,
// registered ALU drive, multi-cycle multiply hold, valid/ready response.
//
// state       | meaning
// ST_IDLE     | waiting for a request; req_ready follows the round-robin grant
// ST_EXEC     | single-cycle op on the ALU, result captured at next edge
// ST_MUL_WAIT | multiply held on the ALU until the down-counter reaches zero
// ST_RESP     | response presented, held until rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture;
  logic              enable;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;

  logic [DATA_W-1:0] sel_op1, sel_op2;
  alu_ctrl_t         sel_ctrl;

  logic [DATA_W-1:0] alu_op1_q, alu_op2_q, rsp_res_q;
  alu_ctrl_t         alu_ctrl_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_zero_q, rsp_err_q;

  assign enable = (state_q == ST_IDLE);
  assign accept = enable && (|grant);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid     (bus.req_valid),
    .enable    (enable),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_ctrl = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op1  = bus.req_op1[i*DATA_W +: DATA_W];
        sel_op2  = bus.req_op2[i*DATA_W +: DATA_W];
        sel_ctrl = bus.req_ctrl[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_legal_ctrl(sel_ctrl)) begin
            state_d = ST_RESP;
          end else if (sel_ctrl == ALU_MUL) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_MUL_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Illegal codes leave the ALU drive untouched and answer with an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_ctrl_q <= '0;
      rsp_id_q   <= '0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rsp_id_q <= grant_idx;
      if (is_legal_ctrl(sel_ctrl)) begin
        alu_op1_q  <= sel_op1;
        alu_op2_q  <= sel_op2;
        alu_ctrl_q <= sel_ctrl;
      end else begin
        rsp_res_q  <= '0;
        rsp_zero_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end
    end else if (capture) begin
      rsp_res_q  <= bus.alu_res;
      rsp_zero_q <= bus.alu_zero;
      rsp_err_q  <= 1'b0;
    end
  end

  assign bus.req_ready = grant;
  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
